// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the UART baud-rate configuration controller:
// baud mode codes, controller state encoding and small elaboration helpers.
package uart_cfg_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_4800      = 3'b000;
    localparam logic [MODE_W-1:0] MODE_9600      = 3'b001;
    localparam logic [MODE_W-1:0] MODE_19200     = 3'b010;
    localparam logic [MODE_W-1:0] MODE_38400     = 3'b011;
    localparam logic [MODE_W-1:0] MODE_57600     = 3'b100;
    localparam logic [MODE_W-1:0] MODE_115200    = 3'b101;
    localparam logic [MODE_W-1:0] MODE_MAX_VALID = 3'b101;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        SETTLE = 2'd1,
        IDLE   = 2'd2,
        DRAIN  = 2'd3
    } cfg_state_e;

    // Largest of three values, used to size the shared counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/uart_clk_edge_detect.sv
// Two-flop synchroniser for an asynchronous clock-like input plus a
// registered one-cycle pulse on each synchronised rising edge.
module uart_clk_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
            o_rise   <= 1'b0;
        end else begin
            r_meta   <= i_async;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
            o_rise   <= r_sync & ~r_sync_d;
        end
    end

endmodule

// File: rtl/uart_baud_config_ctrl.sv
// Run-time baud-rate change sequencer: drains the UART link, applies the new
// mode, pulses the generator reset and waits for the TX clock to settle.
module uart_baud_config_ctrl
    import uart_cfg_pkg::*;
#(
    parameter logic [2:0]  DEFAULT_MODE      = 3'b101,
    parameter int unsigned RESET_HOLD_CYCLES = 4,
    parameter int unsigned SETTLE_TICKS      = 2,
    parameter int unsigned DRAIN_TIMEOUT     = 0
) (
    input  logic        Clk_In,
    input  logic        Reset_N_In,
    input  logic        Cfg_Req_In,
    input  logic [2:0]  Cfg_Mode_In,
    output logic        Cfg_Ack_Out,
    output logic        Cfg_Done_Out,
    output logic        Cfg_Err_Out,
    input  logic        TX_Busy_In,
    input  logic        RX_Busy_In,
    input  logic        TX_UART_Clk_In,
    output logic [2:0]  Baud_Mode_Out,
    output logic        Baud_Reset_Out,
    output logic        Link_Hold_Out,
    output logic        Rate_Ready_Out
);

    localparam int unsigned CNT_MAX = max3(RESET_HOLD_CYCLES, DRAIN_TIMEOUT, SETTLE_TICKS);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST  =
        CNT_W'((DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1);

    cfg_state_e       r_state;
    cfg_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [2:0]       r_pending;
    logic [2:0]       w_pending_nxt;
    logic [2:0]       w_mode_nxt;
    logic             w_ack_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_tx_rise;

    uart_clk_edge_detect u_tx_edge (
        .i_clk   (Clk_In),
        .i_rst_n (Reset_N_In),
        .i_async (TX_UART_Clk_In),
        .o_rise  (w_tx_rise)
    );

    // Shared counter never wraps: it parks at its maximum value.
    assign w_cnt_inc = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pending_nxt = r_pending;
        w_mode_nxt    = Baud_Mode_Out;
        w_ack_nxt     = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            HOLD: begin
                if (r_cnt >= HOLD_LAST) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            SETTLE: begin
                if (w_tx_rise) begin
                    if (r_cnt >= SETTLE_LAST) begin
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            IDLE: begin
                if (Cfg_Req_In) begin
                    if (Cfg_Mode_In > MODE_MAX_VALID) begin
                        w_err_nxt = 1'b1;
                    end else if (Cfg_Mode_In == Baud_Mode_Out) begin
                        w_ack_nxt  = 1'b1;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_pending_nxt = Cfg_Mode_In;
                        w_ack_nxt     = 1'b1;
                        w_state_nxt   = DRAIN;
                        w_cnt_nxt     = '0;
                    end
                end
            end
            DRAIN: begin
                // A quiet link takes priority over an expiring timeout.
                if (!TX_Busy_In && !RX_Busy_In) begin
                    w_mode_nxt  = r_pending;
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = '0;
                end else if ((DRAIN_TIMEOUT != 0) && (r_cnt >= DRAIN_LAST)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            r_state        <= HOLD;
            r_cnt          <= '0;
            r_pending      <= DEFAULT_MODE;
            Baud_Mode_Out  <= DEFAULT_MODE;
            Baud_Reset_Out <= 1'b1;
            Link_Hold_Out  <= 1'b1;
            Rate_Ready_Out <= 1'b0;
            Cfg_Ack_Out    <= 1'b0;
            Cfg_Done_Out   <= 1'b0;
            Cfg_Err_Out    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_pending      <= w_pending_nxt;
            Baud_Mode_Out  <= w_mode_nxt;
            Baud_Reset_Out <= (w_state_nxt == HOLD);
            Link_Hold_Out  <= (w_state_nxt != IDLE);
            Rate_Ready_Out <= (w_state_nxt == IDLE);
            Cfg_Ack_Out    <= w_ack_nxt;
            Cfg_Done_Out   <= w_done_nxt;
            Cfg_Err_Out    <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_baud_config_ctrl.sv
// Directed bench for uart_baud_config_ctrl: one instance with default
// parameters and one with a 100-cycle drain timeout.
module tb_uart_baud_config_ctrl;

    logic       clk;
    logic       rst_n;
    logic       tx_clk;

    logic       req;
    logic [2:0] mode;
    logic       tx_busy;
    logic       rx_busy;
    logic       ack, done, err;
    logic [2:0] bmode;
    logic       breset, hold, ready;

    logic       req_b;
    logic [2:0] mode_b;
    logic       tx_busy_b;
    logic       rx_busy_b;
    logic       ack_b, done_b, err_b;
    logic [2:0] bmode_b;
    logic       breset_b, hold_b, ready_b;

    int n_total = 0;
    int n_bad   = 0;

    uart_baud_config_ctrl u_dut (
        .Clk_In         (clk),
        .Reset_N_In     (rst_n),
        .Cfg_Req_In     (req),
        .Cfg_Mode_In    (mode),
        .Cfg_Ack_Out    (ack),
        .Cfg_Done_Out   (done),
        .Cfg_Err_Out    (err),
        .TX_Busy_In     (tx_busy),
        .RX_Busy_In     (rx_busy),
        .TX_UART_Clk_In (tx_clk),
        .Baud_Mode_Out  (bmode),
        .Baud_Reset_Out (breset),
        .Link_Hold_Out  (hold),
        .Rate_Ready_Out (ready)
    );

    uart_baud_config_ctrl #(.DRAIN_TIMEOUT(100)) u_dut_to (
        .Clk_In         (clk),
        .Reset_N_In     (rst_n),
        .Cfg_Req_In     (req_b),
        .Cfg_Mode_In    (mode_b),
        .Cfg_Ack_Out    (ack_b),
        .Cfg_Done_Out   (done_b),
        .Cfg_Err_Out    (err_b),
        .TX_Busy_In     (tx_busy_b),
        .RX_Busy_In     (rx_busy_b),
        .TX_UART_Clk_In (tx_clk),
        .Baud_Mode_Out  (bmode_b),
        .Baud_Reset_Out (breset_b),
        .Link_Hold_Out  (hold_b),
        .Rate_Ready_Out (ready_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TX baud clock, unrelated to clk (period 46 ns vs 10 ns).
    initial tx_clk = 1'b0;
    always #23 tx_clk = ~tx_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            tick();
            cyc++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic count_hold(output int cyc, output int early_done);
        cyc        = 0;
        early_done = 0;
        while (breset && cyc < 50) begin
            tick();
            cyc++;
            if (done) early_done++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mode"},  32'(bmode),  5);
        check({tag, "_brst"},  32'(breset), 1);
        check({tag, "_hold"},  32'(hold),   1);
        check({tag, "_ready"}, 32'(ready),  0);
        check({tag, "_pulse"}, 32'({ack, done, err}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc;
        int  early;
        int  chg;
        bit  seen;

        rst_n = 1'b1;
        req = 1'b0; mode = 3'd0; tx_busy = 1'b0; rx_busy = 1'b0;
        req_b = 1'b0; mode_b = 3'd0; tx_busy_b = 1'b0; rx_busy_b = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) tick();

        // 1: power-up sequence
        check_reset_vals("t1_rst");
        rst_n = 1'b1;
        count_hold(cyc, early);
        check("t1_hold_cycles", 32'(cyc), 4);
        check("t1_early_done", 32'(early), 0);
        wait_done(cyc, seen);
        check("t1_done_seen", 32'(seen), 1);
        check("t1_settle_min", 32'(cyc >= 6), 1);
        check("t1_ready", 32'(ready), 1);
        check("t1_mode", 32'(bmode), 5);
        check("t1_hold", 32'(hold), 0);
        tick();
        check("t1_done_pulse", 32'(done), 0);
        check("t1_ready_stay", 32'(ready), 1);

        // 2: change to 9600 on an idle link
        req = 1'b1; mode = 3'b001;
        tick();
        check("t2_ack", 32'(ack), 1);
        check("t2_hold", 32'(hold), 1);
        check("t2_ready", 32'(ready), 0);
        check("t2_mode_old", 32'(bmode), 5);
        req = 1'b0;
        tick();
        check("t2_ack_pulse", 32'(ack), 0);
        check("t2_mode_new", 32'(bmode), 1);
        check("t2_brst", 32'(breset), 1);
        count_hold(cyc, early);
        check("t2_hold_cycles", 32'(cyc), 4);
        wait_done(cyc, seen);
        check("t2_done_seen", 32'(seen), 1);
        check("t2_ready", 32'(ready), 1);
        check("t2_mode", 32'(bmode), 1);

        // 3: change to 38400 while TX busy for 500 cycles
        tx_busy = 1'b1;
        req = 1'b1; mode = 3'b011;
        tick();
        check("t3_ack", 32'(ack), 1);
        req = 1'b0;
        chg = 0;
        repeat (500) begin
            tick();
            if (bmode !== 3'b001 || ready !== 1'b0 || hold !== 1'b1 || breset !== 1'b0) chg++;
        end
        check("t3_drain_stable", 32'(chg), 0);
        tx_busy = 1'b0;
        tick();
        check("t3_mode_new", 32'(bmode), 3);
        check("t3_brst", 32'(breset), 1);
        wait_done(cyc, seen);
        check("t3_done_seen", 32'(seen), 1);
        check("t3_ready", 32'(ready), 1);

        // 4: invalid modes are rejected, same mode is an immediate ack+done
        req = 1'b1; mode = 3'b111;
        tick();
        check("t4_err7", 32'(err), 1);
        check("t4_ack7", 32'(ack), 0);
        check("t4_ready7", 32'(ready), 1);
        check("t4_hold7", 32'(hold), 0);
        req = 1'b0;
        tick();
        check("t4_err_pulse", 32'(err), 0);
        check("t4_mode_keep", 32'(bmode), 3);
        req = 1'b1; mode = 3'b110;
        tick();
        check("t4_err6", 32'(err), 1);
        req = 1'b0;
        tick();
        req = 1'b1; mode = 3'b011;
        tick();
        check("t4_same_ackdone", 32'({ack, done, err}), 3'b110);
        check("t4_same_hold", 32'(hold), 0);
        check("t4_same_ready", 32'(ready), 1);
        req = 1'b0;
        tick();
        check("t4_same_pulse", 32'({ack, done}), 0);
        check("t4_same_mode", 32'(bmode), 3);

        // 5: drain timeout with RX stuck busy (second instance)
        check("t5_ready_b", 32'(ready_b), 1);
        rx_busy_b = 1'b1;
        req_b = 1'b1; mode_b = 3'b010;
        tick();
        check("t5_ack_b", 32'(ack_b), 1);
        req_b = 1'b0;
        cyc = 0;
        while (!err_b && cyc < 300) begin
            tick();
            cyc++;
        end
        check("t5_timeout_cycles", 32'(cyc), 100);
        check("t5_mode_b", 32'(bmode_b), 5);
        check("t5_ready_b_back", 32'(ready_b), 1);
        check("t5_hold_b", 32'(hold_b), 0);
        rx_busy_b = 1'b0;
        tick();

        // 6: reset during SETTLE after a change
        req = 1'b1; mode = 3'b000;
        tick();
        check("t6_ack", 32'(ack), 1);
        req = 1'b0;
        tick();
        count_hold(cyc, early);
        check("t6_in_settle_mode", 32'(bmode), 0);
        check("t6_in_settle_brst", 32'(breset), 0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async");
        repeat (2) tick();
        check_reset_vals("t6_rst");
        rst_n = 1'b1;
        count_hold(cyc, early);
        check("t6_hold_cycles", 32'(cyc), 4);
        check("t6_early_done", 32'(early), 0);
        wait_done(cyc, seen);
        check("t6_done_seen", 32'(seen), 1);
        check("t6_mode_default", 32'(bmode), 5);
        check("t6_ready", 32'(ready), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
